// File: rtl/tc_rescale_pkg.sv
// Shared widths and constants for the tracklet product rescaler.
// Holds default widths, the rounding constant and saturation bounds.
package tc_rescale_pkg;

    localparam int DEF_DIN_W  = 30;
    localparam int DEF_DOUT_W = 18;
    localparam int DEF_SHIFT  = 12;
    localparam int DEF_TAG_W  = 8;
    localparam int DEF_DEPTH  = 4;

    // Half an output LSB, added before the shift for round-half-up
    function automatic longint round_const(input int shift);
        return longint'(1) << (shift - 1);
    endfunction

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    localparam longint DEF_RND     = round_const(DEF_SHIFT);
    localparam longint DEF_SAT_MAX = sat_max(DEF_DOUT_W);
    localparam longint DEF_SAT_MIN = sat_min(DEF_DOUT_W);

endpackage

// File: rtl/tc_rescale_fifo.sv
// Small synchronous FIFO carrying {sat, tag, data} rescaler results.
// Ports: clk/rst (async high), wr_en/wr_data, rd_en/rd_data, empty.
module tc_rescale_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_wr, do_rd;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A write into a full FIFO is legal when the head leaves the same cycle
    assign do_rd = rd_en & (cnt_q != '0);
    assign do_wr = wr_en & ((cnt_q != CW'(DEPTH)) | do_rd);
    assign empty = (cnt_q == '0);

    // Head is forced to zero when empty so no stale payload is visible
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = nxt(wr_ptr_q);
        if (do_rd) rd_ptr_d = nxt(rd_ptr_q);
        if (do_wr & ~do_rd) cnt_d = cnt_q + CW'(1);
        else if (~do_wr & do_rd) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/tc_product_rescaler.sv
// Rounds, shifts and saturates the 30s tracklet product behind a FIFO.
// Ports: din/din_tag valid-ready in, dout/dout_tag/dout_sat valid-ready
// out; ovf_count only when TC_RESCALE_OVF_CNT_EN is defined.
module tc_product_rescaler
    import tc_rescale_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int DOUT_W = DEF_DOUT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DIN_W-1:0]  din,
    input  logic [TAG_W-1:0]  din_tag,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DOUT_W-1:0] dout,
    output logic [TAG_W-1:0]  dout_tag,
    output logic              dout_sat
`ifdef TC_RESCALE_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_count
`endif
);

    localparam int SW = DIN_W + 1;
    localparam int QW = DIN_W + 1 - SHIFT;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = 1 + TAG_W + DOUT_W;

    localparam longint Q_MAX = sat_max(DOUT_W);
    localparam longint Q_MIN = sat_min(DOUT_W);
    localparam logic signed [SW-1:0] RND = SW'(round_const(SHIFT));

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   s1_valid_q, s1_valid_d;
    logic signed [SW-1:0]   s1_sum_q, s1_sum_d;
    logic [TAG_W-1:0]       s1_tag_q, s1_tag_d;

    logic                   in_acc, out_acc;
    logic signed [QW-1:0]   q;
    longint                 q_l;
    logic [DOUT_W-1:0]      res;
    logic                   sat;
    logic [PW-1:0]          head;
    logic                   fifo_empty;

    assign in_acc     = din_valid & din_ready;
    assign out_acc    = dout_valid & dout_ready;
    assign din_ready  = (cnt_q < CW'(DEPTH)) & ~ap_rst;
    assign dout_valid = ~fifo_empty;

    // cnt covers s1 plus FIFO contents, so a valid s1 always finds room
    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = in_acc;
        s1_sum_d   = s1_sum_q;
        s1_tag_d   = s1_tag_q;
        if (in_acc & ~out_acc) cnt_d = cnt_q + CW'(1);
        else if (~in_acc & out_acc) cnt_d = cnt_q - CW'(1);
        if (in_acc) begin
            s1_sum_d = $signed({din[DIN_W-1], din}) + RND;
            s1_tag_d = din_tag;
        end
    end

    always_comb begin
        q   = QW'(s1_sum_q >>> SHIFT);
        q_l = longint'(q);
        res = DOUT_W'(q);
        sat = 1'b0;
        if (q_l > Q_MAX) begin
            res = DOUT_W'(Q_MAX);
            sat = 1'b1;
        end else if (q_l < Q_MIN) begin
            res = DOUT_W'(Q_MIN);
            sat = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_tag_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    tc_rescale_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .wr_en   (s1_valid_q),
        .wr_data ({sat, s1_tag_q, res}),
        .rd_en   (dout_ready),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign dout     = head[DOUT_W-1:0];
    assign dout_tag = head[DOUT_W +: TAG_W];
    assign dout_sat = head[PW-1];

`ifdef TC_RESCALE_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (s1_valid_q & sat & (ovf_q != 16'hFFFF))
            ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_count = ovf_q;
`endif

endmodule

// File: tb/tb_tc_product_rescaler.sv
// Scoreboard bench for tc_product_rescaler.
// Directed vectors with a reference rounding model and queued expectations.
module tb_tc_product_rescaler;

    localparam int DIN_W  = 30;
    localparam int DOUT_W = 18;
    localparam int TAG_W  = 8;

    logic                     ap_clk = 1'b0;
    logic                     ap_rst;
    logic                     din_valid;
    logic                     din_ready;
    logic signed [DIN_W-1:0]  din;
    logic [TAG_W-1:0]         din_tag;
    logic                     dout_valid;
    logic                     dout_ready;
    logic signed [DOUT_W-1:0] dout;
    logic [TAG_W-1:0]         dout_tag;
    logic                     dout_sat;
`ifdef TC_RESCALE_OVF_CNT_EN
    logic [15:0]              ovf_count;
`endif

    tc_product_rescaler dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .din_tag    (din_tag),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_tag   (dout_tag),
        .dout_sat   (dout_sat)
`ifdef TC_RESCALE_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        longint data;
        longint tag;
        longint sat;
        int     stamp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   acc_cnt = 0;
    int   strm_left = 0;
    bit   lat_chk = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: floor((d + 2048) / 4096), then clamp
    function automatic exp_t model(input longint d, input longint tag);
        exp_t   m;
        longint t;
        longint q;
        t = d + 2048;
        if (t >= 0) q = t / 4096;
        else        q = -((-t + 4095) / 4096);
        m.sat = 0;
        if (q > 131071) begin
            q = 131071;
            m.sat = 1;
        end else if (q < -131072) begin
            q = -131072;
            m.sat = 1;
        end
        m.data  = q;
        m.tag   = tag;
        m.stamp = 0;
        return m;
    endfunction

    // Caller is just past a rising edge; returns just past a rising edge
    task automatic send(input longint d, input int tag);
        exp_t e;
        int   n;
        n         = 0;
        din       = DIN_W'(d);
        din_tag   = TAG_W'(tag);
        din_valid = 1'b1;
        forever begin
            @(negedge ap_clk);
            if (din_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 0, 1);
                din_valid = 1'b0;
                return;
            end
        end
        e       = model(d, tag);
        e.stamp = cyc;
        sb.push_back(e);
        acc_cnt++;
        @(posedge ap_clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge ap_clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst) begin
            if (lat_chk && strm_left > 0 && strm_left < 100)
                chk("stream_valid", dout_valid, 1);
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", dout, 999999);
                end else begin
                    e = sb.pop_front();
                    chk("dout", dout, e.data);
                    chk("dout_tag", dout_tag, e.tag);
                    chk("dout_sat", dout_sat, e.sat);
                    if (lat_chk) chk("latency", cyc - e.stamp, 2);
                end
                if (lat_chk && strm_left > 0) strm_left--;
                n_out++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    longint bp_vals [6] = '{100000, -100000, 4096, -4097, 2**29-1, 0};
    logic signed [DIN_W-1:0] r;
    int out_snap;

    initial begin
        ap_rst     = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        din_tag    = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_tag", dout_tag, 0);
        chk("rst_dout_sat", dout_sat, 0);
`ifdef TC_RESCALE_OVF_CNT_EN
        chk("rst_ovf_count", ovf_count, 0);
`endif
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("post_rst_ready", din_ready, 1);
        @(posedge ap_clk);
        #1;

        send(2048, 1);
        send(-2048, 2);
        send(-2049, 3);
        send(4095, 4);
        send(2**29 - 1, 5);
        send(-(2**29), 6);
        wait_drain();
`ifdef TC_RESCALE_OVF_CNT_EN
        chk("ovf_after_sat", ovf_count, 1);
`endif

        @(posedge ap_clk);
        #1;
        dout_ready = 1'b0;
        acc_cnt    = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(bp_vals[i], 16 + i);
            end
        join_none
        repeat (10) @(negedge ap_clk);
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_din_ready", din_ready, 0);
        chk("bp_head_tag", dout_tag, 16);
        dout_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_ready_rise", din_ready, 1);
        for (int n = 0; n < 100 && acc_cnt < 6; n++)
            @(negedge ap_clk);
        chk("bp_total", acc_cnt, 6);
        wait_drain();

        @(posedge ap_clk);
        #1;
        lat_chk   = 1'b1;
        strm_left = 100;
        for (int i = 0; i < 100; i++) begin
            r = DIN_W'($urandom);
            r = r >>> $urandom_range(0, 13);
            send(longint'(r), i);
        end
        wait_drain();
        chk("stream_count", strm_left, 0);
        lat_chk = 1'b0;

        @(posedge ap_clk);
        #1;
        dout_ready = 1'b0;
        send(2**29 - 1, 40);
        send(5000, 41);
        send(-7000, 42);
        repeat (3) @(negedge ap_clk);
        chk("pre_rst_valid", dout_valid, 1);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_ready", din_ready, 0);
`ifdef TC_RESCALE_OVF_CNT_EN
        chk("mid_rst_ovf", ovf_count, 0);
`endif
        sb.delete();
        @(negedge ap_clk);
        ap_rst   = 1'b0;
        out_snap = n_out;
        @(negedge ap_clk);
        chk("rel_din_ready", din_ready, 1);
        dout_ready = 1'b1;
        repeat (6) @(negedge ap_clk);
        chk("no_stale_out", n_out, out_snap);
        chk("no_stale_valid", dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
